// File: rtl/rowptr_nnz_gen.sv
// rowptr_nnz_gen
// Converts a CSR row-pointer stream into per-row non-zero counts.
// Each 64-bit input beat carries two pointers: the low half is the even pointer
// and the high half is the odd one. A pass consumes num_rows+1 pointers and
// emits num_rows counts, each equal to ptr[k+1] - ptr[k] (modulo 2^PTR_W).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, num_rows       begin a pass (ignored while busy)
//   s_axis_rowptr_*       row-pointer beat input (valid/ready)
//   m_axis_times_*        per-row count output (valid/ready)
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   nnz_total             running sum of emitted counts
//   err                   sticky decreasing-pointer flag
//
// Optional feature: define ROWPTR_MONO_CHECK_EN to clamp counts of decreasing
// pointers to zero and raise err. Without it err is tied low.
module rowptr_nnz_gen #(
    parameter int PTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PTR_W-1:0]   num_rows,
    input  logic [2*PTR_W-1:0] s_axis_rowptr_tdata,
    input  logic               s_axis_rowptr_tvalid,
    output logic               s_axis_rowptr_tready,
    output logic [PTR_W-1:0]   m_axis_times_tdata,
    output logic               m_axis_times_tvalid,
    input  logic               m_axis_times_tready,
    output logic               busy,
    output logic               done,
    output logic [PTR_W-1:0]   nnz_total,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     num_rows_q, num_rows_d;
    logic [PTR_W:0]       ptr_cnt_q, ptr_cnt_d;
    logic [2*PTR_W-1:0]   hold_q, hold_d;
    logic                 hold_v_q, hold_v_d;
    logic                 half_q, half_d;
    logic [PTR_W-1:0]     prev_q, prev_d;
    logic [PTR_W-1:0]     out_data_q, out_data_d;
    logic                 out_v_q, out_v_d;
    logic [PTR_W-1:0]     nnz_q, nnz_d;
    logic                 done_q, done_d;

    logic [PTR_W-1:0]     cur_ptr;
    logic [PTR_W-1:0]     count;
    logic                 last_ptr;
    logic                 consume;
    logic                 s_ready;

`ifdef ROWPTR_MONO_CHECK_EN
    logic                 err_q, err_d;
    logic                 ptr_dec;
`endif

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        ptr_cnt_d  = ptr_cnt_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        half_d     = half_q;
        prev_d     = prev_q;
        out_data_d = out_data_q;
        out_v_d    = out_v_q;
        nnz_d      = nnz_q;
        done_d     = 1'b0;
        s_ready    = 1'b0;

        cur_ptr  = half_q ? hold_q[2*PTR_W-1:PTR_W] : hold_q[PTR_W-1:0];
        last_ptr = (ptr_cnt_q == {1'b0, num_rows_q});
        // Pointer 0 produces no output, so it may be consumed even while a
        // count is stalled downstream.
        consume  = (state_q == S_RUN) & hold_v_q &
                   ((ptr_cnt_q == '0) | !out_v_q | m_axis_times_tready);

`ifdef ROWPTR_MONO_CHECK_EN
        err_d   = err_q;
        ptr_dec = (cur_ptr < prev_q);
        count   = ptr_dec ? '0 : (cur_ptr - prev_q);
`else
        count   = cur_ptr - prev_q;
`endif

        if (out_v_q && m_axis_times_tready) begin
            out_v_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    nnz_d = '0;
`ifdef ROWPTR_MONO_CHECK_EN
                    err_d = 1'b0;
`endif
                    if (num_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        num_rows_d = num_rows;
                        ptr_cnt_d  = '0;
                        hold_v_d   = 1'b0;
                        half_d     = 1'b0;
                        state_d    = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (consume) begin
                    ptr_cnt_d = ptr_cnt_q + (PTR_W+1)'(1);
                    prev_d    = cur_ptr;
                    if (ptr_cnt_q != '0) begin
                        out_data_d = count;
                        out_v_d    = 1'b1;
                        nnz_d      = nnz_q + count;
`ifdef ROWPTR_MONO_CHECK_EN
                        if (ptr_dec) begin
                            err_d = 1'b1;
                        end
`endif
                    end
                    if (half_q || last_ptr) begin
                        hold_v_d = 1'b0;
                    end else begin
                        half_d = 1'b1;
                    end
                    if (last_ptr) begin
                        state_d = S_DRAIN;
                    end
                end
                // A new beat is only useful while pointers remain after the
                // one being consumed; the high half of the final beat is
                // simply dropped when the hold register clears.
                if (hold_v_q) begin
                    s_ready = consume & half_q & !last_ptr;
                end else begin
                    s_ready = (ptr_cnt_q <= {1'b0, num_rows_q});
                end
                if (s_ready && s_axis_rowptr_tvalid) begin
                    hold_d   = s_axis_rowptr_tdata;
                    hold_v_d = 1'b1;
                    half_d   = 1'b0;
                end
            end

            S_DRAIN: begin
                if (!out_v_q || m_axis_times_tready) begin
                    out_v_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_rows_q <= '0;
            ptr_cnt_q  <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            half_q     <= 1'b0;
            prev_q     <= '0;
            out_data_q <= '0;
            out_v_q    <= 1'b0;
            nnz_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            ptr_cnt_q  <= ptr_cnt_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            half_q     <= half_d;
            prev_q     <= prev_d;
            out_data_q <= out_data_d;
            out_v_q    <= out_v_d;
            nnz_q      <= nnz_d;
            done_q     <= done_d;
        end
    end

`ifdef ROWPTR_MONO_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign s_axis_rowptr_tready = s_ready;
    assign m_axis_times_tdata   = out_data_q;
    assign m_axis_times_tvalid  = out_v_q;
    assign busy                 = (state_q != S_IDLE);
    assign done                 = done_q;
    assign nnz_total            = nnz_q;

endmodule

// File: tb/tb_rowptr_nnz_gen.sv
// Self-checking bench for rowptr_nnz_gen: directed passes followed by random
// passes, all compared against a pointer-difference model.
module tb_rowptr_nnz_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num_rows;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [31:0] nnz;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] ptrs[$];

    rowptr_nnz_gen #(.PTR_W(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_rows             (num_rows),
        .s_axis_rowptr_tdata  (s_data),
        .s_axis_rowptr_tvalid (s_valid),
        .s_axis_rowptr_tready (s_ready),
        .m_axis_times_tdata   (m_data),
        .m_axis_times_tvalid  (m_valid),
        .m_axis_times_tready  (m_ready),
        .busy                 (busy),
        .done                 (done),
        .nnz_total            (nnz),
        .err                  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"},  m_data, 0);
        chk({tag, "_busy"},    32'(busy), 0);
        chk({tag, "_done"},    32'(done), 0);
        chk({tag, "_nnz"},     nnz, 0);
        chk({tag, "_err"},     32'(err), 0);
    endtask

    // mode 0: ready/valid always high; 1: ready pattern 1,0,0; 2: random both
    // abort_after != 0: assert reset right after that many counts are taken.
    task automatic run_pass(input int n, input int mode, input int abort_after);
        logic [31:0] exp_q[$];
        logic [63:0] beats[$];
        logic [31:0] exp_nnz;
        logic        exp_err;
        logic [31:0] a, b, c, prev_data;
        int bi, oi, first_beat, first_out;
        bit last_hs, finished, stall_prev;

        exp_nnz = 0;
        exp_err = 1'b0;
        for (int k = 1; k <= n; k++) begin
            a = ptrs[k-1];
            b = ptrs[k];
`ifdef ROWPTR_MONO_CHECK_EN
            if (b < a) begin
                c = 0;
                exp_err = 1'b1;
            end else begin
                c = b - a;
            end
`else
            c = b - a;
`endif
            exp_q.push_back(c);
            exp_nnz = exp_nnz + c;
        end
        for (int j = 0; j <= n; j += 2) begin
            beats.push_back({(j + 1 <= n) ? ptrs[j+1] : 32'hFFFF_FFFF, ptrs[j]});
        end

        @(negedge clk);
        start    = 1'b1;
        num_rows = 32'(n);
        s_valid  = 1'b0;
        m_ready  = 1'b1;

        bi = 0; oi = 0; first_beat = -1; first_out = -1;
        last_hs = 0; finished = 0; stall_prev = 0; prev_data = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start    = (mode == 2 && busy && $urandom_range(0, 7) == 0);
            num_rows = $urandom;
            if (bi < beats.size()) begin
                s_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data  = beats[bi];
            end else begin
                s_valid = 1'b1;
                s_data  = {$urandom, $urandom};
            end
            m_ready = (mode == 0) ? 1'b1 :
                      (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) chk("busy_rise", 32'(busy), 1);
            if (last_hs) begin
                chk("done_pulse", 32'(done), 1);
                chk("busy_end",   32'(busy), 0);
                chk("nnz_total",  nnz, exp_nnz);
                chk("err_flag",   32'(err), 32'(exp_err));
                finished = 1;
                break;
            end
            chk("done_idle", 32'(done), 0);
            if (stall_prev) begin
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_data",  m_data, prev_data);
            end
            if (bi >= beats.size()) chk("no_extra_beat", 32'(s_ready), 0);
            if (s_valid && s_ready) begin
                if (first_beat < 0) first_beat = cyc;
                bi++;
            end
            if (m_valid && first_out < 0) begin
                first_out = cyc;
                if (mode == 0) chk("first_latency", 32'(first_out - first_beat), 3);
            end
            if (m_valid && m_ready) begin
                chk("count_in_range", 32'(oi < n), 1);
                if (oi < n) chk("count", m_data, exp_q[oi]);
                oi++;
                if (oi == n) last_hs = 1;
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            if (abort_after != 0 && oi == abort_after) begin
                @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_reset("mid_reset");
                @(negedge clk);
                rst     = 1'b0;
                s_valid = 1'b0;
                start   = 1'b0;
                return;
            end
        end
        if (!finished) begin
            errors++;
            $error("FAIL timeout observed_counts=%0d expected_counts=%0d", oi, n);
        end
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("done_single", 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_rows = 0; s_data = 0; s_valid = 0; m_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        ptrs = '{32'd0, 32'd4, 32'd4, 32'd9};
        run_pass(3, 0, 0);
        run_pass(3, 1, 0);

        ptrs = '{32'd3, 32'd7, 32'd10};
        run_pass(2, 0, 0);

        // Zero-row pass
        @(negedge clk);
        start = 1'b1; num_rows = 0; s_valid = 1'b1; s_data = 64'h1234;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done",   32'(done), 1);
        chk("zero_busy",   32'(busy), 0);
        chk("zero_nnz",    nnz, 0);
        chk("zero_sready", 32'(s_ready), 0);
        @(negedge clk);
        #1;
        chk("zero_done_end", 32'(done), 0);
        chk("zero_sready2",  32'(s_ready), 0);
        s_valid = 1'b0;

        ptrs = '{32'd0, 32'd5, 32'd2, 32'd6};
        run_pass(3, 0, 0);

        ptrs = '{32'd0, 32'd4, 32'd4, 32'd9};
        run_pass(3, 2, 2);
        run_pass(3, 0, 0);

        for (int t = 0; t < 10; t++) begin
            int n;
            logic [31:0] p;
            n = $urandom_range(1, 17);
            ptrs.delete();
            p = $urandom_range(0, 1000);
            ptrs.push_back(p);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0) p = $urandom;
                else p = p + $urandom_range(0, 9);
                ptrs.push_back(p);
            end
            run_pass(n, $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
